// File: rtl/enc_pwm_mixer_if.sv
// Signal bundle between an encoder/PWM mixer and whatever drives its knobs and consumes its outputs.
// The master side owns the raw encoder lines and fade control; the slave side returns PWM, levels and busy.
interface enc_pwm_mixer_if #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8
);
    logic [CHANNELS-1:0]       enc_a;
    logic [CHANNELS-1:0]       enc_b;
    logic                      fade_en;
    logic [CHANNELS-1:0]       pwm_out;
    logic [CHANNELS*WIDTH-1:0] level_out;
    logic                      busy;

    modport master (
        output enc_a, enc_b, fade_en,
        input  pwm_out, level_out, busy
    );

    modport slave (
        input  enc_a, enc_b, fade_en,
        output pwm_out, level_out, busy
    );
endinterface

// File: rtl/enc_pwm_mixer.sv
// N-channel quadrature-encoder to PWM mixer: per-channel debounce, detent decode, optional
// rate-limited fade, and a shared free-running PWM counter with wrap-aligned duty updates.
module enc_pwm_mixer #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int HIST_LEN = 8,
    parameter int FADE_DIV = 256,
    parameter int SATURATE = 1
) (
    input logic             clk,
    input logic             reset,
    enc_pwm_mixer_if.slave  bus
);
    localparam int               PS_W    = $clog2(FADE_DIV);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(FADE_DIV - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [WIDTH-1:0] LVL_MAX = '1;
    localparam logic [WIDTH-1:0] LVL_ONE = WIDTH'(1);

    logic [HIST_LEN-1:0] r_histA [CHANNELS];
    logic [HIST_LEN-1:0] r_histB [CHANNELS];
    logic [CHANNELS-1:0] r_dbA;
    logic [CHANNELS-1:0] r_dbB;
    logic [CHANNELS-1:0] r_prevA;

    logic [WIDTH-1:0]    r_target  [CHANNELS];
    logic [WIDTH-1:0]    r_current [CHANNELS];
    logic [WIDTH-1:0]    r_applied [CHANNELS];
    logic [WIDTH-1:0]    r_pwmCount;
    logic [PS_W-1:0]     r_prescale;
    logic [CHANNELS-1:0] r_pwm;
    logic                r_busy;

    logic [WIDTH-1:0]    w_nextTarget  [CHANNELS];
    logic [WIDTH-1:0]    w_nextCurrent [CHANNELS];
    logic                w_tick;
    logic                w_wrap;
    logic                w_anyDiff;

    assign w_tick = (r_prescale == PS_LAST);
    assign w_wrap = (r_pwmCount == LVL_MAX);

    // A debounced output only flips once the whole history agrees, so short glitches never reach decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_histA[i] <= '0;
                r_histB[i] <= '0;
            end
            r_dbA   <= '0;
            r_dbB   <= '0;
            r_prevA <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_histA[i] <= {r_histA[i][HIST_LEN-2:0], bus.enc_a[i]};
                r_histB[i] <= {r_histB[i][HIST_LEN-2:0], bus.enc_b[i]};
                if (&r_histA[i]) begin
                    r_dbA[i] <= 1'b1;
                end else if (~|r_histA[i]) begin
                    r_dbA[i] <= 1'b0;
                end
                if (&r_histB[i]) begin
                    r_dbB[i] <= 1'b1;
                end else if (~|r_histB[i]) begin
                    r_dbB[i] <= 1'b0;
                end
            end
            r_prevA <= r_dbA;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_nextTarget[i]  = r_target[i];
            w_nextCurrent[i] = r_current[i];
            if (r_dbA[i] && !r_prevA[i]) begin
                if (!r_dbB[i]) begin
                    if (SATURATE == 0 || r_target[i] != LVL_MAX) begin
                        w_nextTarget[i] = r_target[i] + LVL_ONE;
                    end
                end else begin
                    if (SATURATE == 0 || r_target[i] != '0) begin
                        w_nextTarget[i] = r_target[i] - LVL_ONE;
                    end
                end
            end
            // Fading steps toward the target as it stood before this edge's decode.
            if (!bus.fade_en) begin
                w_nextCurrent[i] = r_target[i];
            end else if (w_tick) begin
                if (r_current[i] < r_target[i]) begin
                    w_nextCurrent[i] = r_current[i] + LVL_ONE;
                end else if (r_current[i] > r_target[i]) begin
                    w_nextCurrent[i] = r_current[i] - LVL_ONE;
                end
            end
        end
    end

    always_comb begin
        w_anyDiff = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_current[i] != r_target[i]) begin
                w_anyDiff = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_target[i]  <= '0;
                r_current[i] <= '0;
            end
            r_prescale <= '0;
            r_busy     <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_target[i]  <= w_nextTarget[i];
                r_current[i] <= w_nextCurrent[i];
            end
            r_prescale <= w_tick ? '0 : r_prescale + PS_ONE;
            r_busy     <= w_anyDiff;
        end
    end

    // Duty changes are latched only at the counter wrap so no PWM period is ever truncated.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_applied[i] <= '0;
            end
            r_pwmCount <= '0;
            r_pwm      <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wrap) begin
                    r_applied[i] <= r_current[i];
                end
                r_pwm[i] <= (r_pwmCount < r_applied[i]);
            end
            r_pwmCount <= r_pwmCount + LVL_ONE;
        end
    end

    assign bus.pwm_out = r_pwm;
    assign bus.busy    = r_busy;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_level
        assign bus.level_out[g*WIDTH +: WIDTH] = r_applied[g];
    end
endmodule

// File: tb/tb_enc_pwm_mixer.sv
// Bench for enc_pwm_mixer: a saturating and a wrapping instance share the same encoder stimulus
// and are compared against hand-derived levels, duty counts and fade/debounce timing.
module tb_enc_pwm_mixer;
    localparam int CH = 3;
    localparam int W  = 8;
    localparam int HL = 8;
    localparam int FD = 64;

    typedef struct {
        int          ch;
        bit          fwd;
        int          n;
        logic [23:0] expSat;
        logic [23:0] expWrap;
    } vec_t;

    typedef struct {
        logic [23:0] sat;
        logic [23:0] wrap;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cyc = 0;
    int   firstHigh;
    int   dropCyc;
    int   lvlMid;
    int   pwmHigh;
    int   busyHigh;
    int   cntS [CH];
    int   cntW [CH];
    vec_t vecs [6];
    exp_t sb [$];
    exp_t cur;

    always #5 clk = ~clk;

    enc_pwm_mixer_if #(.CHANNELS(CH), .WIDTH(W)) satIf ();
    enc_pwm_mixer_if #(.CHANNELS(CH), .WIDTH(W)) wrapIf ();

    assign wrapIf.enc_a   = satIf.enc_a;
    assign wrapIf.enc_b   = satIf.enc_b;
    assign wrapIf.fade_en = satIf.fade_en;

    enc_pwm_mixer #(.CHANNELS(CH), .WIDTH(W), .HIST_LEN(HL), .FADE_DIV(FD), .SATURATE(1)) dutSat (
        .clk   (clk),
        .reset (reset),
        .bus   (satIf)
    );

    enc_pwm_mixer #(.CHANNELS(CH), .WIDTH(W), .HIST_LEN(HL), .FADE_DIV(FD), .SATURATE(0)) dutWrap (
        .clk   (clk),
        .reset (reset),
        .bus   (wrapIf)
    );

    // Edges since the last reset-low edge; the fade prescaler phase follows directly from it.
    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyReset(input bit toggle);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (toggle) begin
                satIf.enc_a = CH'($urandom);
                satIf.enc_b = CH'($urandom);
            end
            @(negedge clk);
        end
        satIf.enc_a = '0;
        satIf.enc_b = '0;
        reset = 1'b1;
    endtask

    task automatic detent(input int ch, input bit fwd);
        if (fwd) begin
            satIf.enc_a[ch] = 1'b1; repeat (10) @(negedge clk);
            satIf.enc_b[ch] = 1'b1; repeat (10) @(negedge clk);
            satIf.enc_a[ch] = 1'b0; repeat (10) @(negedge clk);
            satIf.enc_b[ch] = 1'b0; repeat (10) @(negedge clk);
        end else begin
            satIf.enc_b[ch] = 1'b1; repeat (10) @(negedge clk);
            satIf.enc_a[ch] = 1'b1; repeat (10) @(negedge clk);
            satIf.enc_b[ch] = 1'b0; repeat (10) @(negedge clk);
            satIf.enc_a[ch] = 1'b0; repeat (10) @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        for (int d = 0; d < v.n; d++) detent(v.ch, v.fwd);
        e.sat  = v.expSat;
        e.wrap = v.expWrap;
        sb.push_back(e);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{ch: 1, fwd: 1'b1, n: 3, expSat: 24'h000300, expWrap: 24'h000300};
        vecs[1] = '{ch: 0, fwd: 1'b0, n: 1, expSat: 24'h000300, expWrap: 24'h0003FF};
        vecs[2] = '{ch: 0, fwd: 1'b1, n: 1, expSat: 24'h000301, expWrap: 24'h000300};
        vecs[3] = '{ch: 2, fwd: 1'b1, n: 2, expSat: 24'h020301, expWrap: 24'h020300};
        vecs[4] = '{ch: 1, fwd: 1'b0, n: 4, expSat: 24'h020001, expWrap: 24'h02FF00};
        vecs[5] = '{ch: 1, fwd: 1'b1, n: 1, expSat: 24'h020101, expWrap: 24'h020000};

        satIf.enc_a   = '0;
        satIf.enc_b   = '0;
        satIf.fade_en = 1'b0;

        // Reset with inputs toggling, then idle with inputs low.
        applyReset(1'b1);
        checkOutput("rst_level_sat", satIf.level_out, 0);
        checkOutput("rst_pwm_sat", satIf.pwm_out, 0);
        checkOutput("rst_busy_sat", satIf.busy, 0);
        checkOutput("rst_level_wrap", wrapIf.level_out, 0);
        checkOutput("rst_pwm_wrap", wrapIf.pwm_out, 0);
        checkOutput("rst_busy_wrap", wrapIf.busy, 0);
        pwmHigh = 0;
        busyHigh = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (satIf.pwm_out != 0 || wrapIf.pwm_out != 0) pwmHigh++;
            if (satIf.busy || wrapIf.busy) busyHigh++;
        end
        checkOutput("idle_pwm", pwmHigh, 0);
        checkOutput("idle_busy", busyHigh, 0);

        // A 7-sample pulse must not survive debounce.
        @(negedge clk);
        satIf.enc_a[0] = 1'b1;
        repeat (7) @(negedge clk);
        satIf.enc_a[0] = 1'b0;
        busyHigh = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (satIf.busy || wrapIf.busy) busyHigh++;
        end
        checkOutput("glitch_busy", busyHigh, 0);

        // 12-sample pulse: target moves at edge E+9, so busy pulses after edge E+10.
        @(negedge clk);
        satIf.enc_a[0] = 1'b1;
        firstHigh = -1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (satIf.busy && firstHigh < 0) firstHigh = k;
            if (k == 11) satIf.enc_a[0] = 1'b0;
        end
        checkOutput("debounce_latency", firstHigh, HL + 2);
        repeat (300) @(posedge clk);
        #1;
        checkOutput("glitch_level_sat", satIf.level_out, 24'h000001);
        checkOutput("glitch_level_wrap", wrapIf.level_out, 24'h000001);

        // Fade: five detents on ch2 outrun the 64-clock ticks, so current lands on 5 at tick 5.
        satIf.fade_en = 1'b1;
        applyReset(1'b0);
        firstHigh = -1;
        dropCyc   = -1;
        lvlMid    = -1;
        fork
            begin
                for (int d = 0; d < 5; d++) detent(2, 1'b1);
            end
            begin
                for (int k = 0; k < 400 && dropCyc < 0; k++) begin
                    @(posedge clk); #1;
                    if (cyc == 300) lvlMid = satIf.level_out[2*W +: W];
                    if (satIf.busy && firstHigh < 0) firstHigh = cyc;
                    else if (!satIf.busy && firstHigh >= 0) dropCyc = cyc;
                end
            end
        join
        checkOutput("fade_busy_rise", firstHigh, 11);
        checkOutput("fade_busy_drop", dropCyc, 5 * FD + 1);
        checkOutput("fade_mid_level", lvlMid, 3);
        while (cyc < 520) @(posedge clk);
        #1;
        checkOutput("fade_final_sat", satIf.level_out, 24'h050000);
        checkOutput("fade_final_wrap", wrapIf.level_out, 24'h050000);

        // Reset in the middle of a fade clears everything on the very next edge.
        applyReset(1'b0);
        for (int d = 0; d < 5; d++) detent(2, 1'b1);
        repeat (58) @(negedge clk);
        checkOutput("midfade_busy_pre", satIf.busy, 1);
        checkOutput("midfade_pwm_pre", satIf.pwm_out, 3'b100);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("midfade_level_sat", satIf.level_out, 0);
        checkOutput("midfade_busy_sat", satIf.busy, 0);
        checkOutput("midfade_pwm_sat", satIf.pwm_out, 0);
        checkOutput("midfade_level_wrap", wrapIf.level_out, 0);
        checkOutput("midfade_busy_wrap", wrapIf.busy, 0);
        checkOutput("midfade_pwm_wrap", wrapIf.pwm_out, 0);
        satIf.fade_en = 1'b0;
        applyReset(1'b0);

        // Table of detent sequences with per-instance expected levels and duty cycles.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            repeat (260) @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checkOutput($sformatf("sb_empty_%0d", i), 0, 1);
            end else begin
                cur = sb.pop_front();
                checkOutput($sformatf("vec%0d_level_sat", i), satIf.level_out, cur.sat);
                checkOutput($sformatf("vec%0d_level_wrap", i), wrapIf.level_out, cur.wrap);
                for (int c = 0; c < CH; c++) begin
                    cntS[c] = 0;
                    cntW[c] = 0;
                end
                repeat (256) begin
                    @(posedge clk); #1;
                    for (int c = 0; c < CH; c++) begin
                        cntS[c] += int'(satIf.pwm_out[c]);
                        cntW[c] += int'(wrapIf.pwm_out[c]);
                    end
                end
                for (int c = 0; c < CH; c++) begin
                    checkOutput($sformatf("vec%0d_duty_sat_ch%0d", i, c), cntS[c], cur.sat[c*W +: W]);
                    checkOutput($sformatf("vec%0d_duty_wrap_ch%0d", i, c), cntW[c], cur.wrap[c*W +: W]);
                end
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
